ball_mover_2d: RTL and testbench
================================

Name: ball_mover_2d

Overview:
- Parametrised successor to the single-axis ball position generator: drives both X and Y of the game ball from one tick timebase.
- Adds configurable speed and step, arena bounds, per-axis paddle-collision reversal, serve/pause control, and optional goal (miss) detection on the X walls.
- Sits between the collision detector and the ball renderer; x_pos/y_pos feed the draw pipeline directly.

Parameters:
- POS_W, 12, width of x_pos/y_pos
- TICK_PERIOD, 800_000, pclk cycles per motion step (>=2)
- STEP, 1, pixels moved per tick per axis (1..15)
- X_MIN, 10, smallest legal x_pos
- X_MAX, 1013, largest legal x_pos
- Y_MIN, 10, smallest legal y_pos
- Y_MAX, 757, largest legal y_pos
- X_START, 220, x_pos after reset/miss
- Y_START, 384, y_pos after reset/miss
- GOAL_MODE, 0, 0 = X walls bounce; 1 = X walls score a miss

Ports:
- pclk  in  1  system pixel clock
- reset  in  1  synchronous, active-low reset
- serve  in  1  launch request, sampled in WAIT only
- serve_dir_x  in  1  initial X direction on serve (1 = +x)
- pause  in  1  level; freezes tick counter and position
- collision_x  in  1  paddle hit requiring X reversal (pulse or level)
- collision_y  in  1  hit requiring Y reversal
- x_pos  out  POS_W  ball X, registered
- y_pos  out  POS_W  ball Y, registered
- dir_x  out  1  current X direction (1 = +x)
- dir_y  out  1  current Y direction (1 = +y)
- moving  out  1  high in RUN
- miss  out  1  one-cycle pulse on goal
- miss_side  out  1  valid with miss: 0 = X_MIN wall, 1 = X_MAX wall

Behaviour:
- One clock (pclk); reset is synchronous and active-low. Reset: state=WAIT, x_pos=X_START, y_pos=Y_START, dir_x=1, dir_y=1, moving=0, miss=0, miss_side=0, tick counter=TICK_PERIOD-1, collision latches cleared. Reset overrides everything, including mid-RUN.
- States: WAIT, RUN, MISS.
- WAIT: position held at start, counter held at TICK_PERIOD-1. serve=1 -> RUN next cycle, dir_x=serve_dir_x, dir_y=1. pause is ignored in WAIT.
- RUN: counter decrements each cycle when pause=0; on counter==0 (the tick) it reloads TICK_PERIOD-1 and one step is applied. Ticks occur exactly TICK_PERIOD cycles apart. The new position is visible the cycle after the tick cycle.
- pause=1 in RUN: counter, position and directions frozen. Collision latches still capture.
- Collision latches: collision_x/collision_y set a sticky flag any cycle in RUN. The flag is consumed and cleared at the next tick; multiple hits between ticks count as one.
- Per-axis step at tick, X shown; Y is identical with Y bounds and no goal:
  - Wall hit: dir=1 and x_pos+STEP >= X_MAX, or dir=0 and x_pos <= X_MIN+STEP.
    - GOAL_MODE=0: x_pos clamps to the wall value, dir flips.
    - GOAL_MODE=1: enter MISS.
  - Otherwise, latched collision: dir flips and x_pos moves STEP in the new direction.
  - Otherwise: x_pos moves STEP in dir.
  - Wall and collision on the same tick: wall rule only, a single reversal, latch cleared.
- Arithmetic is unsigned POS_W. Bounds guarantee no wrap. Positions never leave [MIN,MAX].
- MISS: lasts one cycle. miss=1, miss_side=wall hit, moving=0. Position is not updated on the goal tick. Next cycle: x/y reload start values, state=WAIT, latches cleared.
- Both axes are evaluated in the same tick. An X goal takes precedence; Y still does not update on that tick.

Test Plan:
- TICK_PERIOD=4, reset low 3 cycles then high, serve=1 with serve_dir_x=1 -> x_pos 220->221 exactly 4 cycles after entering RUN, then +1 every 4 cycles; y_pos 384->385 on the same ticks.
- X_MAX=225, GOAL_MODE=0, start 220 moving +x -> x_pos 221..224, then clamps to 225 with dir_x=0, then 224 on the next tick.
- collision_x pulsed for 1 cycle mid-period while x_pos=230, dir +x -> on the next tick x_pos=229, dir_x=0; a second pulse within the same period causes no extra reversal.
- GOAL_MODE=1, X_MIN=10, ball at 11 moving -x -> miss=1 and miss_side=0 for exactly one cycle, then x_pos=220, y_pos=384, moving=0; a serve 2 cycles later relaunches.
- pause held 10 cycles in RUN -> x_pos, y_pos and counter unchanged; after release the next tick lands at the remaining count.
- reset asserted mid-RUN at x_pos=500 -> next edge x_pos=220, state WAIT, miss=0, latched collision discarded.

Source files
------------

// File: rtl/ball_mover_2d.sv
// Two-axis ball position generator: tick timebase, wall bounce or goal,
// sticky paddle-collision reversal and serve/pause control.
module ball_mover_2d #(
  parameter int POS_W       = 12,
  parameter int TICK_PERIOD = 800_000,
  parameter int STEP        = 1,
  parameter int X_MIN       = 10,
  parameter int X_MAX       = 1013,
  parameter int Y_MIN       = 10,
  parameter int Y_MAX       = 757,
  parameter int X_START     = 220,
  parameter int Y_START     = 384,
  parameter int GOAL_MODE   = 0
) (
  input  logic             pclk,
  input  logic             reset,
  input  logic             serve,
  input  logic             serve_dir_x,
  input  logic             pause,
  input  logic             collision_x,
  input  logic             collision_y,
  output logic [POS_W-1:0] x_pos,
  output logic [POS_W-1:0] y_pos,
  output logic             dir_x,
  output logic             dir_y,
  output logic             moving,
  output logic             miss,
  output logic             miss_side
);

  localparam int CNT_W = $clog2(TICK_PERIOD);
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(TICK_PERIOD - 1);
  localparam logic [POS_W-1:0] STP  = POS_W'(STEP);
  localparam logic [POS_W-1:0] XMIN = POS_W'(X_MIN);
  localparam logic [POS_W-1:0] XMAX = POS_W'(X_MAX);
  localparam logic [POS_W-1:0] YMIN = POS_W'(Y_MIN);
  localparam logic [POS_W-1:0] YMAX = POS_W'(Y_MAX);
  localparam logic [POS_W-1:0] XST  = POS_W'(X_START);
  localparam logic [POS_W-1:0] YST  = POS_W'(Y_START);

  typedef enum logic [1:0] {WAIT, RUN, MISS} state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [POS_W-1:0] x_nx, y_nx;
  logic             dx_nx, dy_nx;
  logic             cx_l, cy_l, cx_nx, cy_nx;
  logic             side_nx;
  logic             hit_x, goal;
  logic [POS_W:0]   sx, sy;

  // Returns {new_dir, new_pos}; wall beats collision, and a reversed
  // move is clamped so the ball can never leave [lo,hi].
  function automatic logic [POS_W:0] step_axis(
    input logic [POS_W-1:0] pos,
    input logic             dir,
    input logic             col,
    input logic [POS_W-1:0] lo,
    input logic [POS_W-1:0] hi
  );
    logic d;
    if (dir && (pos + STP >= hi)) return {1'b0, hi};
    if (!dir && (pos <= lo + STP)) return {1'b1, lo};
    d = col ? !dir : dir;
    if (d) return {d, (pos + STP >= hi) ? hi : pos + STP};
    return {d, (pos <= lo + STP) ? lo : pos - STP};
  endfunction

  assign hit_x = dir_x ? (x_pos + STP >= XMAX) : (x_pos <= XMIN + STP);
  assign goal  = (GOAL_MODE != 0) && hit_x;
  assign sx    = step_axis(x_pos, dir_x, cx_l | collision_x, XMIN, XMAX);
  assign sy    = step_axis(y_pos, dir_y, cy_l | collision_y, YMIN, YMAX);

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    x_nx     = x_pos;
    y_nx     = y_pos;
    dx_nx    = dir_x;
    dy_nx    = dir_y;
    cx_nx    = cx_l;
    cy_nx    = cy_l;
    side_nx  = miss_side;
    unique case (state)
      WAIT: begin
        cnt_nx = CNT_TOP;
        x_nx   = XST;
        y_nx   = YST;
        cx_nx  = 1'b0;
        cy_nx  = 1'b0;
        if (serve) begin
          state_nx = RUN;
          dx_nx    = serve_dir_x;
          dy_nx    = 1'b1;
        end
      end
      RUN: begin
        cx_nx = cx_l | collision_x;
        cy_nx = cy_l | collision_y;
        if (!pause) begin
          if (cnt == '0) begin
            cnt_nx = CNT_TOP;
            cx_nx  = 1'b0;
            cy_nx  = 1'b0;
            if (goal) begin
              state_nx = MISS;
              side_nx  = dir_x;
            end else begin
              {dx_nx, x_nx} = sx;
              {dy_nx, y_nx} = sy;
            end
          end else begin
            cnt_nx = cnt - 1'b1;
          end
        end
      end
      MISS: begin
        state_nx = WAIT;
        cnt_nx   = CNT_TOP;
        x_nx     = XST;
        y_nx     = YST;
        cx_nx    = 1'b0;
        cy_nx    = 1'b0;
      end
      default: state_nx = WAIT;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (!reset) begin
      state     <= WAIT;
      cnt       <= CNT_TOP;
      x_pos     <= XST;
      y_pos     <= YST;
      dir_x     <= 1'b1;
      dir_y     <= 1'b1;
      cx_l      <= 1'b0;
      cy_l      <= 1'b0;
      miss_side <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      x_pos     <= x_nx;
      y_pos     <= y_nx;
      dir_x     <= dx_nx;
      dir_y     <= dy_nx;
      cx_l      <= cx_nx;
      cy_l      <= cy_nx;
      miss_side <= side_nx;
    end
  end

  assign moving = (state == RUN);
  assign miss   = (state == MISS);

endmodule

// File: tb/tb_ball_mover_2d.sv
// Directed bench: bounce instance driven from a vector table, goal
// instance driven by hand-written collision/miss/reset sequences.
module tb_ball_mover_2d;

  logic pclk = 1'b0;
  always #5 pclk = ~pclk;

  logic        rst0, srv0, sdx0, pau0, cx0, cy0;
  logic [11:0] x0, y0;
  logic        dx0, dy0, mv0, ms0, sd0;

  logic        rst1, srv1, sdx1, pau1, cx1, cy1;
  logic [11:0] x1, y1;
  logic        dx1, dy1, mv1, ms1, sd1;

  ball_mover_2d #(
    .TICK_PERIOD(4), .X_MAX(225), .Y_MAX(388)
  ) u0 (
    .pclk(pclk), .reset(rst0), .serve(srv0), .serve_dir_x(sdx0),
    .pause(pau0), .collision_x(cx0), .collision_y(cy0),
    .x_pos(x0), .y_pos(y0), .dir_x(dx0), .dir_y(dy0),
    .moving(mv0), .miss(ms0), .miss_side(sd0)
  );

  ball_mover_2d #(
    .TICK_PERIOD(4), .GOAL_MODE(1)
  ) u1 (
    .pclk(pclk), .reset(rst1), .serve(srv1), .serve_dir_x(sdx1),
    .pause(pau1), .collision_x(cx1), .collision_y(cy1),
    .x_pos(x1), .y_pos(y1), .dir_x(dx1), .dir_y(dy1),
    .moving(mv1), .miss(ms1), .miss_side(sd1)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge pclk);
    #1;
  endtask

  typedef struct {
    int   n;
    logic p;
    int   x;
    int   y;
    logic dx;
    logic dy;
    logic mv;
  } vec_t;

  vec_t tbl[11];

  initial begin
    tbl[0]  = '{3,  1'b0, 220, 384, 1'b1, 1'b1, 1'b1};
    tbl[1]  = '{1,  1'b0, 221, 385, 1'b1, 1'b1, 1'b1};
    tbl[2]  = '{4,  1'b0, 222, 386, 1'b1, 1'b1, 1'b1};
    tbl[3]  = '{4,  1'b0, 223, 387, 1'b1, 1'b1, 1'b1};
    tbl[4]  = '{4,  1'b0, 224, 388, 1'b1, 1'b0, 1'b1};
    tbl[5]  = '{4,  1'b0, 225, 387, 1'b0, 1'b0, 1'b1};
    tbl[6]  = '{4,  1'b0, 224, 386, 1'b0, 1'b0, 1'b1};
    tbl[7]  = '{2,  1'b0, 224, 386, 1'b0, 1'b0, 1'b1};
    tbl[8]  = '{10, 1'b1, 224, 386, 1'b0, 1'b0, 1'b1};
    tbl[9]  = '{1,  1'b0, 224, 386, 1'b0, 1'b0, 1'b1};
    tbl[10] = '{1,  1'b0, 223, 385, 1'b0, 1'b0, 1'b1};

    {rst0, srv0, sdx0, pau0, cx0, cy0} = '0;
    {rst1, srv1, sdx1, pau1, cx1, cy1} = '0;
    cyc(3);
    chk("rst_x", x0, 220);
    chk("rst_y", y0, 384);
    chk("rst_dx", dx0, 1);
    chk("rst_dy", dy0, 1);
    chk("rst_mv", mv0, 0);
    chk("rst_miss", ms0, 0);
    chk("rst_side", sd0, 0);
    rst0 = 1'b1;
    rst1 = 1'b1;
    cyc(2);
    chk("wait_hold_x", x0, 220);
    chk("wait_mv", mv0, 0);

    // bounce instance: serve then table
    srv0 = 1'b1;
    sdx0 = 1'b1;
    cyc(1);
    srv0 = 1'b0;
    chk("serve_mv", mv0, 1);
    for (int i = 0; i < 11; i++) begin
      pau0 = tbl[i].p;
      cyc(tbl[i].n);
      chk($sformatf("v%0d_x", i), x0, tbl[i].x);
      chk($sformatf("v%0d_y", i), y0, tbl[i].y);
      chk($sformatf("v%0d_dx", i), dx0, tbl[i].dx);
      chk($sformatf("v%0d_dy", i), dy0, tbl[i].dy);
      chk($sformatf("v%0d_mv", i), mv0, tbl[i].mv);
    end
    pau0 = 1'b0;

    // goal instance: run to 230, then collision pulses
    chk("u1_wait_x", x1, 220);
    srv1 = 1'b1;
    sdx1 = 1'b1;
    cyc(1);
    srv1 = 1'b0;
    cyc(40);
    chk("c_pre_x", x1, 230);
    chk("c_pre_y", y1, 394);
    cx1 = 1'b1;
    cyc(1);
    cx1 = 1'b0;
    cyc(1);
    cx1 = 1'b1;
    cyc(1);
    cx1 = 1'b0;
    cyc(1);
    chk("c_tick_x", x1, 229);
    chk("c_tick_dx", dx1, 0);
    chk("c_tick_y", y1, 395);
    cyc(4);
    chk("c_next_x", x1, 228);
    chk("c_next_dx", dx1, 0);

    // drift to the X_MIN goal
    cyc(217 * 4);
    chk("g_pre_x", x1, 11);
    chk("g_pre_y", y1, 613);
    cyc(3);
    chk("g_hold_miss", ms1, 0);
    chk("g_hold_mv", mv1, 1);
    cyc(1);
    chk("g_miss", ms1, 1);
    chk("g_side", sd1, 0);
    chk("g_mv", mv1, 0);
    chk("g_x_frozen", x1, 11);
    chk("g_y_frozen", y1, 613);
    cyc(1);
    chk("g_after_miss", ms1, 0);
    chk("g_after_x", x1, 220);
    chk("g_after_y", y1, 384);
    chk("g_after_mv", mv1, 0);
    cyc(1);
    srv1 = 1'b1;
    sdx1 = 1'b1;
    cyc(1);
    srv1 = 1'b0;
    chk("re_mv", mv1, 1);
    cyc(4);
    chk("re_x", x1, 221);
    chk("re_y", y1, 385);

    // reset mid-run with a pending collision
    cyc(279 * 4);
    chk("m_pre_x", x1, 500);
    cx1 = 1'b1;
    cyc(1);
    cx1 = 1'b0;
    rst1 = 1'b0;
    cyc(1);
    chk("m_rst_x", x1, 220);
    chk("m_rst_y", y1, 384);
    chk("m_rst_mv", mv1, 0);
    chk("m_rst_miss", ms1, 0);
    chk("m_rst_dx", dx1, 1);
    rst1 = 1'b1;
    srv1 = 1'b1;
    sdx1 = 1'b1;
    cyc(1);
    srv1 = 1'b0;
    cyc(4);
    chk("m_latch_x", x1, 221);
    chk("m_latch_dx", dx1, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
